xbar_master_interface: RTL and testbench

XBAR_MASTER_INTERFACE -- requirements
Module: xbar_master_interface

---
 rtl/xbar_pkg.sv | 26 ++
 rtl/xbar_beat_counter.sv | 25 ++
 rtl/xbar_master_interface.sv | 231 +++++++++++++++++++++++
 tb/tb_xbar_master_interface.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared FSM state types and AXI burst/response encodings
package xbar_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/xbar_beat_counter.sv
// rtl/xbar_beat_counter.sv - burst beat counter flagging the beat whose index equals len
module xbar_beat_counter #(
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 last_o
);

  logic [LEN_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == len_i);

endmodule

// File: rtl/xbar_master_interface.sv
// rtl/xbar_master_interface.sv - crossbar-to-slave AXI bridge with independent read/write FSMs
module xbar_master_interface
  import xbar_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int IDS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int masters    = 2,
  localparam int MW        = (masters > 1) ? $clog2(masters) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ar_req_valid,
  output logic                  ar_req_ready,
  input  logic [MW-1:0]         ar_req_master,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [LEN_WIDTH-1:0]  ARLEN,
  input  logic [SIZE_WIDTH-1:0] ARSIZE,
  input  logic [1:0]            ARBURST,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [MW-1:0]         r_dest_master,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  input  logic                  aw_req_valid,
  output logic                  aw_req_ready,
  input  logic [MW-1:0]         aw_req_master,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [LEN_WIDTH-1:0]  AWLEN,
  input  logic [SIZE_WIDTH-1:0] AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [MW-1:0]         b_dest_master,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic [IDS_WIDTH-1:0]  ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [LEN_WIDTH-1:0]  ARLEN_S,
  output logic [SIZE_WIDTH-1:0] ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S,
  input  logic [IDS_WIDTH-1:0]  RID_S,
  input  logic [DATA_WIDTH-1:0] RDATA_S,
  input  logic [1:0]            RRESP_S,
  input  logic                  RLAST_S,
  input  logic                  RVALID_S,
  output logic                  RREADY_S,
  output logic [IDS_WIDTH-1:0]  AWID_S,
  output logic [ADDR_WIDTH-1:0] AWADDR_S,
  output logic [LEN_WIDTH-1:0]  AWLEN_S,
  output logic [SIZE_WIDTH-1:0] AWSIZE_S,
  output logic [1:0]            AWBURST_S,
  output logic                  AWVALID_S,
  input  logic                  AWREADY_S,
  output logic [DATA_WIDTH-1:0] WDATA_S,
  output logic [STRB_WIDTH-1:0] WSTRB_S,
  output logic                  WLAST_S,
  output logic                  WVALID_S,
  input  logic                  WREADY_S,
  input  logic [IDS_WIDTH-1:0]  BID_S,
  input  logic [1:0]            BRESP_S,
  input  logic                  BVALID_S,
  output logic                  BREADY_S,
  output logic                  rd_len_err,
  output logic                  wr_len_err
);

  rd_state_t             rd_state_q, rd_state_d;
  logic [MW-1:0]         rd_master_q;
  logic [ID_WIDTH-1:0]   rd_id_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]  rd_len_q;
  logic [SIZE_WIDTH-1:0] rd_size_q;
  logic [1:0]            rd_burst_q;
  logic                  rd_err_q;
  logic                  rd_beat, rd_clr, rd_last;

  wr_state_t             wr_state_q, wr_state_d;
  logic [MW-1:0]         wr_master_q;
  logic [ID_WIDTH-1:0]   wr_id_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LEN_WIDTH-1:0]  wr_len_q;
  logic [SIZE_WIDTH-1:0] wr_size_q;
  logic [1:0]            wr_burst_q;
  logic                  wr_err_q;
  logic                  wr_beat, wr_clr, wr_last;

  assign rd_beat = (rd_state_q == RD_DATA) && RVALID_S && r_ready;
  assign rd_clr  = (rd_state_q == RD_ADDR) && ARREADY_S;
  assign wr_beat = (wr_state_q == WR_DATA) && w_valid && WREADY_S;
  assign wr_clr  = (wr_state_q == WR_ADDR) && AWREADY_S;

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (ar_req_valid) rd_state_d = RD_ADDR;
      RD_ADDR: if (ARREADY_S) rd_state_d = RD_DATA;
      RD_DATA: if (rd_beat && RLAST_S) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q  <= RD_IDLE;
      rd_master_q <= '0;
      rd_id_q     <= '0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rd_size_q   <= '0;
      rd_burst_q  <= BURST_INCR;
      rd_err_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_state_q == RD_IDLE && ar_req_valid) begin
        rd_master_q <= ar_req_master;
        rd_id_q     <= ARID;
        rd_addr_q   <= ARADDR;
        rd_len_q    <= ARLEN;
        rd_size_q   <= ARSIZE;
        rd_burst_q  <= ARBURST;
      end
      // The slave's RLAST must land exactly on beat ARLEN; anything else is sticky.
      if (rd_beat && (RLAST_S != rd_last)) rd_err_q <= 1'b1;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (aw_req_valid) wr_state_d = WR_ADDR;
      WR_ADDR: if (AWREADY_S) wr_state_d = WR_DATA;
      WR_DATA: if (wr_beat && wr_last) wr_state_d = WR_RESP;
      WR_RESP: if (BVALID_S && b_ready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q  <= WR_IDLE;
      wr_master_q <= '0;
      wr_id_q     <= '0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
      wr_size_q   <= '0;
      wr_burst_q  <= BURST_INCR;
      wr_err_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      if (wr_state_q == WR_IDLE && aw_req_valid) begin
        wr_master_q <= aw_req_master;
        wr_id_q     <= AWID;
        wr_addr_q   <= AWADDR;
        wr_len_q    <= AWLEN;
        wr_size_q   <= AWSIZE;
        wr_burst_q  <= AWBURST;
      end
      if (wr_beat && (WLAST != wr_last)) wr_err_q <= 1'b1;
    end
  end

  xbar_beat_counter #(.LEN_WIDTH(LEN_WIDTH)) u_rd_cnt (
    .clk_i(ACLK), .rst_i(ARESET), .clr_i(rd_clr), .inc_i(rd_beat),
    .len_i(rd_len_q), .last_o(rd_last)
  );

  xbar_beat_counter #(.LEN_WIDTH(LEN_WIDTH)) u_wr_cnt (
    .clk_i(ACLK), .rst_i(ARESET), .clr_i(wr_clr), .inc_i(wr_beat),
    .len_i(wr_len_q), .last_o(wr_last)
  );

  // Slave-side ID carries the master number above the crossbar ID, zero-padded on top.
  assign ARID_S    = IDS_WIDTH'({rd_master_q, rd_id_q});
  assign ARADDR_S  = rd_addr_q;
  assign ARLEN_S   = rd_len_q;
  assign ARSIZE_S  = rd_size_q;
  assign ARBURST_S = rd_burst_q;
  assign ARVALID_S = (rd_state_q == RD_ADDR);
  assign ar_req_ready = (rd_state_q == RD_IDLE);

  assign r_valid       = (rd_state_q == RD_DATA) && RVALID_S;
  assign RREADY_S      = (rd_state_q == RD_DATA) && r_ready;
  assign r_dest_master = rd_master_q;
  assign RID           = RID_S[ID_WIDTH-1:0];
  assign RDATA         = RDATA_S;
  assign RRESP         = RRESP_S;
  assign RLAST         = RLAST_S;

  assign AWID_S    = IDS_WIDTH'({wr_master_q, wr_id_q});
  assign AWADDR_S  = wr_addr_q;
  assign AWLEN_S   = wr_len_q;
  assign AWSIZE_S  = wr_size_q;
  assign AWBURST_S = wr_burst_q;
  assign AWVALID_S = (wr_state_q == WR_ADDR);
  assign aw_req_ready = (wr_state_q == WR_IDLE);

  assign WVALID_S = (wr_state_q == WR_DATA) && w_valid;
  assign w_ready  = (wr_state_q == WR_DATA) && WREADY_S;
  assign WDATA_S  = WDATA;
  assign WSTRB_S  = WSTRB;
  assign WLAST_S  = wr_last;

  assign b_valid       = (wr_state_q == WR_RESP) && BVALID_S;
  assign BREADY_S      = (wr_state_q == WR_RESP) && b_ready;
  assign b_dest_master = wr_master_q;
  assign BID           = BID_S[ID_WIDTH-1:0];
  assign BRESP         = BRESP_S;

  assign rd_len_err = rd_err_q;
  assign wr_len_err = wr_err_q;

  logic unused_id_bits;
  assign unused_id_bits = ^{RID_S[IDS_WIDTH-1:ID_WIDTH], BID_S[IDS_WIDTH-1:ID_WIDTH]};

endmodule

// File: tb/tb_xbar_master_interface.sv
// tb/tb_xbar_master_interface.sv - directed self-checking bench for xbar_master_interface
module tb_xbar_master_interface;

  localparam int IW = 4, ISW = 8, AW = 32, LW = 4, SW = 3, DW = 32, STW = 4, MW = 1;

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic ar_req_valid = 0, ar_req_ready;
  logic [MW-1:0] ar_req_master = 0;
  logic [IW-1:0] ARID = 0;
  logic [AW-1:0] ARADDR = 0;
  logic [LW-1:0] ARLEN = 0;
  logic [SW-1:0] ARSIZE = 0;
  logic [1:0] ARBURST = 0;
  logic r_valid, r_ready = 0;
  logic [MW-1:0] r_dest_master;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0] RRESP;
  logic RLAST;
  logic aw_req_valid = 0, aw_req_ready;
  logic [MW-1:0] aw_req_master = 0;
  logic [IW-1:0] AWID = 0;
  logic [AW-1:0] AWADDR = 0;
  logic [LW-1:0] AWLEN = 0;
  logic [SW-1:0] AWSIZE = 0;
  logic [1:0] AWBURST = 0;
  logic w_valid = 0, w_ready;
  logic [DW-1:0] WDATA = 0;
  logic [STW-1:0] WSTRB = 0;
  logic WLAST = 0;
  logic b_valid, b_ready = 0;
  logic [MW-1:0] b_dest_master;
  logic [IW-1:0] BID;
  logic [1:0] BRESP;
  logic [ISW-1:0] ARID_S, AWID_S;
  logic [AW-1:0] ARADDR_S, AWADDR_S;
  logic [LW-1:0] ARLEN_S, AWLEN_S;
  logic [SW-1:0] ARSIZE_S, AWSIZE_S;
  logic [1:0] ARBURST_S, AWBURST_S;
  logic ARVALID_S, ARREADY_S = 0, AWVALID_S, AWREADY_S = 0;
  logic [ISW-1:0] RID_S = 0, BID_S = 0;
  logic [DW-1:0] RDATA_S = 0, WDATA_S;
  logic [1:0] RRESP_S = 0, BRESP_S = 0;
  logic RLAST_S = 0, RVALID_S = 0, RREADY_S;
  logic [STW-1:0] WSTRB_S;
  logic WLAST_S, WVALID_S, WREADY_S = 0;
  logic BVALID_S = 0, BREADY_S;
  logic rd_len_err, wr_len_err;

  int vectors = 0, miscompares = 0;

  xbar_master_interface dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ar_req_valid(ar_req_valid), .ar_req_ready(ar_req_ready), .ar_req_master(ar_req_master),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .r_valid(r_valid), .r_ready(r_ready), .r_dest_master(r_dest_master),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .aw_req_valid(aw_req_valid), .aw_req_ready(aw_req_ready), .aw_req_master(aw_req_master),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .w_valid(w_valid), .w_ready(w_ready), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest_master(b_dest_master), .BID(BID), .BRESP(BRESP),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .rd_len_err(rd_len_err), .wr_len_err(wr_len_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rd_got, wr_got, b_got, cyc;
    bit rd_addr_done, wr_addr_done;

    // Reset state
    step(); step();
    #1;
    chk("rst_arvalid", ARVALID_S, 0);
    chk("rst_awvalid", AWVALID_S, 0);
    chk("rst_wvalid", WVALID_S, 0);
    chk("rst_rready", RREADY_S, 0);
    chk("rst_bready", BREADY_S, 0);
    chk("rst_wready", w_ready, 0);
    chk("rst_rd_err", rd_len_err, 0);
    chk("rst_wr_err", wr_len_err, 0);
    ARESET = 0;
    step();
    #1;
    chk("rel_ar_ready", ar_req_ready, 1);
    chk("rel_aw_ready", aw_req_ready, 1);

    // Read: ARID=3, master 1, ARLEN=3
    step();
    ar_req_valid = 1; ar_req_master = 1; ARID = 4'd3; ARADDR = 32'h1000_0040;
    ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'd1;
    #1;
    chk("r1_ar_ready", ar_req_ready, 1);
    step();
    ar_req_valid = 0;
    #1;
    chk("r1_arvalid", ARVALID_S, 1);
    chk("r1_arid_s", ARID_S, 8'h13);
    chk("r1_araddr_s", ARADDR_S, 32'h1000_0040);
    chk("r1_arlen_s", ARLEN_S, 3);
    chk("r1_ar_busy", ar_req_ready, 0);
    chk("r1_rvalid_gated", r_valid, 0);
    ARREADY_S = 1;
    step();
    ARREADY_S = 0;
    for (int k = 0; k < 4; k++) begin
      RVALID_S = 1; RID_S = 8'h13; RDATA_S = 32'hA000 + k; RLAST_S = (k == 3); r_ready = 1;
      #1;
      chk("r1_rvalid", r_valid, 1);
      chk("r1_rready_s", RREADY_S, 1);
      chk("r1_dest", r_dest_master, 1);
      chk("r1_rid", RID, 3);
      chk("r1_rdata", RDATA, 32'hA000 + k);
      step();
    end
    #1;
    chk("r1_rvalid_after", r_valid, 0);
    chk("r1_rready_after", RREADY_S, 0);
    chk("r1_idle", ar_req_ready, 1);
    chk("r1_rd_err", rd_len_err, 0);
    RVALID_S = 0; r_ready = 0; RLAST_S = 0;

    // Write: AWLEN=0, master 0, AWID=5
    step();
    aw_req_valid = 1; aw_req_master = 0; AWID = 4'd5; AWLEN = 4'd0; AWADDR = 32'h2000_0000;
    step();
    aw_req_valid = 0;
    #1;
    chk("w1_awvalid", AWVALID_S, 1);
    chk("w1_awid_s", AWID_S, 8'h05);
    AWREADY_S = 1;
    step();
    AWREADY_S = 0;
    w_valid = 1; WLAST = 1; WDATA = 32'hBEEF; WSTRB = 4'hF; WREADY_S = 1;
    #1;
    chk("w1_wvalid_s", WVALID_S, 1);
    chk("w1_wready", w_ready, 1);
    chk("w1_wlast_s", WLAST_S, 1);
    chk("w1_wdata_s", WDATA_S, 32'hBEEF);
    step();
    w_valid = 0; WLAST = 0;
    BVALID_S = 1; BID_S = 8'h05; BRESP_S = 2'd0; b_ready = 1;
    #1;
    chk("w1_wvalid_off", WVALID_S, 0);
    chk("w1_bvalid", b_valid, 1);
    chk("w1_bid", BID, 5);
    chk("w1_bdest", b_dest_master, 0);
    chk("w1_bready_s", BREADY_S, 1);
    chk("w1_wr_err", wr_len_err, 0);
    step();
    #1;
    chk("w1_bvalid_after", b_valid, 0);
    chk("w1_idle", aw_req_ready, 1);
    BVALID_S = 0; b_ready = 0; WREADY_S = 0;

    // Write: AWLEN=2, upstream WLAST early on beat 1
    step();
    aw_req_valid = 1; aw_req_master = 1; AWID = 4'd2; AWLEN = 4'd2;
    step();
    aw_req_valid = 0;
    #1;
    chk("w2_awid_s", AWID_S, 8'h12);
    AWREADY_S = 1;
    step();
    AWREADY_S = 0;
    for (int k = 0; k < 3; k++) begin
      w_valid = 1; WREADY_S = 1; WLAST = (k == 1); WDATA = 32'hC0 + k;
      #1;
      chk("w2_wlast_s", WLAST_S, (k == 2));
      step();
      #1;
      chk("w2_wr_err", wr_len_err, (k >= 1));
    end
    w_valid = 0; WLAST = 0; WREADY_S = 0;
    BVALID_S = 1; BID_S = 8'h12; b_ready = 1;
    #1;
    chk("w2_bvalid", b_valid, 1);
    chk("w2_bdest", b_dest_master, 1);
    step();
    BVALID_S = 0; b_ready = 0;
    #1;
    chk("w2_err_sticky", wr_len_err, 1);
    chk("w2_idle", aw_req_ready, 1);

    // Concurrent read ARLEN=7 (master 0, id 7) and write AWLEN=7 (master 1, id 9)
    step();
    ar_req_valid = 1; ar_req_master = 0; ARID = 4'd7; ARLEN = 4'd7;
    aw_req_valid = 1; aw_req_master = 1; AWID = 4'd9; AWLEN = 4'd7;
    step();
    ar_req_valid = 0; aw_req_valid = 0;
    rd_got = 0; wr_got = 0; b_got = 0; rd_addr_done = 0; wr_addr_done = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      ARREADY_S = 1'($urandom);
      AWREADY_S = 1'($urandom);
      RVALID_S = rd_addr_done && (rd_got < 8) && 1'($urandom);
      RID_S = 8'h07; RDATA_S = 32'h100 + rd_got; RLAST_S = (rd_got == 7);
      r_ready = 1'($urandom);
      w_valid = (wr_got < 8) && 1'($urandom);
      WDATA = 32'h200 + wr_got; WLAST = (wr_got == 7);
      WREADY_S = 1'($urandom);
      BVALID_S = (wr_got == 8) && (b_got == 0);
      BID_S = 8'h19;
      b_ready = 1'($urandom);
      #1;
      if (ARVALID_S && ARREADY_S) begin
        chk("c_arid_s", ARID_S, 8'h07);
        rd_addr_done = 1;
      end
      if (AWVALID_S && AWREADY_S) begin
        chk("c_awid_s", AWID_S, 8'h19);
        wr_addr_done = 1;
      end
      if (r_valid && r_ready) begin
        chk("c_rdata", RDATA, 32'h100 + rd_got);
        chk("c_rdest", r_dest_master, 0);
        rd_got++;
      end
      if (WVALID_S && WREADY_S) begin
        chk("c_wdata_s", WDATA_S, 32'h200 + wr_got);
        chk("c_wlast_s", WLAST_S, (wr_got == 7));
        wr_got++;
      end
      if (b_valid && b_ready) begin
        chk("c_bid", BID, 9);
        chk("c_bdest", b_dest_master, 1);
        b_got++;
      end
      step();
      if (rd_got == 8 && b_got == 1) break;
    end
    ARREADY_S = 0; AWREADY_S = 0; RVALID_S = 0; RLAST_S = 0; r_ready = 0;
    w_valid = 0; WLAST = 0; WREADY_S = 0; BVALID_S = 0; b_ready = 0;
    #1;
    chk("c_done", (rd_got == 8 && b_got == 1), 1);
    chk("c_rd_beats", rd_got, 8);
    chk("c_wr_beats", wr_got, 8);
    chk("c_ar_idle", ar_req_ready, 1);
    chk("c_aw_idle", aw_req_ready, 1);
    chk("c_rd_err", rd_len_err, 0);
    chk("c_wr_err_sticky", wr_len_err, 1);

    // Read with slave RLAST early: ARLEN=1, RLAST on beat 0
    step();
    ar_req_valid = 1; ar_req_master = 1; ARID = 4'd4; ARLEN = 4'd1;
    step();
    ar_req_valid = 0; ARREADY_S = 1;
    step();
    ARREADY_S = 0;
    RVALID_S = 1; RID_S = 8'h14; RLAST_S = 1; r_ready = 1;
    step();
    RVALID_S = 0; RLAST_S = 0; r_ready = 0;
    #1;
    chk("e_rd_err", rd_len_err, 1);
    chk("e_idle", ar_req_ready, 1);

    // Reset during R beat 2 of 4
    step();
    ar_req_valid = 1; ar_req_master = 0; ARID = 4'd1; ARLEN = 4'd3;
    step();
    ar_req_valid = 0; ARREADY_S = 1;
    step();
    ARREADY_S = 0;
    for (int k = 0; k < 2; k++) begin
      RVALID_S = 1; RID_S = 8'h01; RLAST_S = 0; r_ready = 1;
      step();
    end
    ARESET = 1;
    #1;
    chk("x_beat2_visible", r_valid, 1);
    step();
    ARESET = 0;
    #1;
    chk("x_rvalid", r_valid, 0);
    chk("x_rready_s", RREADY_S, 0);
    chk("x_rd_err", rd_len_err, 0);
    chk("x_wr_err", wr_len_err, 0);
    step();
    #1;
    chk("x_ar_ready", ar_req_ready, 1);
    chk("x_rvalid_after", r_valid, 0);
    RVALID_S = 0; r_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
